// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: axis segment states,
// control register indices and VGACR0 bit positions.
package vga_pkg;

  typedef enum logic [1:0] {
    AXIS_ACTIVE = 2'd0,
    AXIS_FRONT  = 2'd1,
    AXIS_SYNC   = 2'd2,
    AXIS_BACK   = 2'd3
  } axis_state_t;

  localparam int TIMR0  = 0;
  localparam int TIMR1  = 1;
  localparam int TIMR2  = 2;
  localparam int TIMR3  = 3;
  localparam int TIMR4  = 4;
  localparam int TIMR5  = 5;
  localparam int TIMR6  = 6;
  localparam int TIMR7  = 7;
  localparam int TIMR8  = 8;
  localparam int TIMR9  = 9;
  localparam int VGACR0 = 10;

  localparam int CR_ENABLE_BIT = 0;
  localparam int CR_HPOL_BIT   = 1;
  localparam int CR_VPOL_BIT   = 2;

  // Segment that follows cur, skipping any blanking segment of zero length
  function automatic axis_state_t next_segment(input axis_state_t cur,
                                               input logic has_front,
                                               input logic has_sync,
                                               input logic has_back);
    axis_state_t nxt;
    case (cur)
      AXIS_ACTIVE: nxt = has_front ? AXIS_FRONT :
                         (has_sync ? AXIS_SYNC : (has_back ? AXIS_BACK : AXIS_ACTIVE));
      AXIS_FRONT:  nxt = has_sync ? AXIS_SYNC : (has_back ? AXIS_BACK : AXIS_ACTIVE);
      AXIS_SYNC:   nxt = has_back ? AXIS_BACK : AXIS_ACTIVE;
      AXIS_BACK:   nxt = AXIS_ACTIVE;
      default:     nxt = AXIS_ACTIVE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: walks ACTIVE -> FRONT -> SYNC -> BACK, each segment lasting
// its programmed number of advance steps; zero-length blanking segments are skipped.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [CNT_WIDTH-1:0] len_active,
  input  logic [CNT_WIDTH-1:0] len_front,
  input  logic [CNT_WIDTH-1:0] len_sync,
  input  logic [CNT_WIDTH-1:0] len_back,
  output axis_state_t          state,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 last
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  axis_state_t          state_r;
  axis_state_t          state_nxt_s;
  axis_state_t          seg_next_s;
  logic [CNT_WIDTH-1:0] count_r;
  logic [CNT_WIDTH-1:0] count_nxt_s;
  logic [CNT_WIDTH-1:0] seg_len_s;
  logic                 seg_end_s;

  // Length of the segment currently being counted
  always_comb begin
    seg_len_s = len_active;
    case (state_r)
      AXIS_ACTIVE: seg_len_s = len_active;
      AXIS_FRONT:  seg_len_s = len_front;
      AXIS_SYNC:   seg_len_s = len_sync;
      AXIS_BACK:   seg_len_s = len_back;
      default:     seg_len_s = len_active;
    endcase
  end

  assign seg_end_s  = (count_r == (seg_len_s - CNT_ONE));
  assign seg_next_s = next_segment(state_r, (len_front != CNT_ZERO),
                                   (len_sync != CNT_ZERO), (len_back != CNT_ZERO));

  // Next state and segment count
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    if (clear) begin
      state_nxt_s = AXIS_ACTIVE;
      count_nxt_s = CNT_ZERO;
    end else if (advance) begin
      if (seg_end_s) begin
        state_nxt_s = seg_next_s;
        count_nxt_s = CNT_ZERO;
      end else begin
        state_nxt_s = state_r;
        count_nxt_s = count_r + CNT_ONE;
      end
    end else begin
      state_nxt_s = state_r;
      count_nxt_s = count_r;
    end
  end

  // State and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= AXIS_ACTIVE;
      count_r <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign state = state_r;
  assign count = count_r;
  assign last  = seg_end_s && (seg_next_s == AXIS_ACTIVE);

endmodule

// File: rtl/vga_timing_generator.sv
// VGA sync/data-enable generator with frame-boundary register shadowing.
// Define VGA_TIMING_VBLANK_IRQ_EN to add the vblank interrupt (irq_ack / vblank_irq).
module vga_timing_generator
  import vga_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int NUM_VGA_CONT_REG = 11,
  parameter int CNT_WIDTH        = 12
) (
  input  logic                                   clock,
  input  logic                                   reset,
`ifdef VGA_TIMING_VBLANK_IRQ_EN
  input  logic                                   irq_ack,
  output logic                                   vblank_irq,
`endif
  input  logic [NUM_VGA_CONT_REG*DATA_WIDTH-1:0] control_reg_in,
  output logic                                   hsync,
  output logic                                   vsync,
  output logic                                   de,
  output logic [CNT_WIDTH-1:0]                   pixel_x,
  output logic [CNT_WIDTH-1:0]                   pixel_y,
  output logic                                   line_start,
  output logic                                   frame_start
);

  localparam int BUS_W = NUM_VGA_CONT_REG * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [BUS_W-1:0]        shadow_r;
  logic [DATA_WIDTH-1:0]   cr_live_s;
  logic [DATA_WIDTH-1:0]   cr_sh_s;
  logic [2*DATA_WIDTH-1:0] h_active_w_s;
  logic [2*DATA_WIDTH-1:0] v_active_w_s;
  logic [CNT_WIDTH-1:0]    h_active_s, h_front_s, h_sync_s, h_back_s;
  logic [CNT_WIDTH-1:0]    v_active_s, v_front_s, v_sync_s, v_back_s;
  logic                    idle_s;
  logic                    frame_end_s;
  logic                    unused_s;

  axis_state_t             h_state_s, v_state_s;
  logic [CNT_WIDTH-1:0]    h_count_s, v_count_s;
  logic                    h_last_s, v_last_s;

  logic                    de_s, hsync_s, vsync_s, line_start_s, frame_start_s;
  logic [CNT_WIDTH-1:0]    pixel_x_s, pixel_y_s;
  logic                    de_r, hsync_r, vsync_r, line_start_r, frame_start_r;
  logic [CNT_WIDTH-1:0]    pixel_x_r, pixel_y_r;

  assign cr_live_s    = control_reg_in[VGACR0*DATA_WIDTH +: DATA_WIDTH];
  assign cr_sh_s      = shadow_r[VGACR0*DATA_WIDTH +: DATA_WIDTH];
  assign h_active_w_s = {shadow_r[TIMR1*DATA_WIDTH +: DATA_WIDTH], shadow_r[TIMR0*DATA_WIDTH +: DATA_WIDTH]};
  assign v_active_w_s = {shadow_r[TIMR6*DATA_WIDTH +: DATA_WIDTH], shadow_r[TIMR5*DATA_WIDTH +: DATA_WIDTH]};
  // Active lengths are 16-bit registers; bits above the counter width are dropped
  assign h_active_s   = h_active_w_s[CNT_WIDTH-1:0];
  assign v_active_s   = v_active_w_s[CNT_WIDTH-1:0];
  assign h_front_s    = CNT_WIDTH'(shadow_r[TIMR2*DATA_WIDTH +: DATA_WIDTH]);
  assign h_sync_s     = CNT_WIDTH'(shadow_r[TIMR3*DATA_WIDTH +: DATA_WIDTH]);
  assign h_back_s     = CNT_WIDTH'(shadow_r[TIMR4*DATA_WIDTH +: DATA_WIDTH]);
  assign v_front_s    = CNT_WIDTH'(shadow_r[TIMR7*DATA_WIDTH +: DATA_WIDTH]);
  assign v_sync_s     = CNT_WIDTH'(shadow_r[TIMR8*DATA_WIDTH +: DATA_WIDTH]);
  assign v_back_s     = CNT_WIDTH'(shadow_r[TIMR9*DATA_WIDTH +: DATA_WIDTH]);
  assign unused_s     = ^{h_active_w_s, v_active_w_s, cr_sh_s, cr_live_s};

  assign idle_s      = ~cr_sh_s[CR_ENABLE_BIT] | (h_active_s == CNT_ZERO) | (v_active_s == CNT_ZERO);
  assign frame_end_s = ~idle_s & h_last_s & v_last_s;

  // Shadow copy of the register bank, refreshed only while idle or at frame end
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_r <= {BUS_W{1'b0}};
    end else if (idle_s || frame_end_s) begin
      shadow_r <= control_reg_in;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  vga_axis_counter #(.CNT_WIDTH(CNT_WIDTH)) u_h_axis (
    .clock      (clock),
    .reset      (reset),
    .clear      (idle_s),
    .advance    (1'b1),
    .len_active (h_active_s),
    .len_front  (h_front_s),
    .len_sync   (h_sync_s),
    .len_back   (h_back_s),
    .state      (h_state_s),
    .count      (h_count_s),
    .last       (h_last_s)
  );

  vga_axis_counter #(.CNT_WIDTH(CNT_WIDTH)) u_v_axis (
    .clock      (clock),
    .reset      (reset),
    .clear      (idle_s),
    .advance    (h_last_s),
    .len_active (v_active_s),
    .len_front  (v_front_s),
    .len_sync   (v_sync_s),
    .len_back   (v_back_s),
    .state      (v_state_s),
    .count      (v_count_s),
    .last       (v_last_s)
  );

  // Decode counter position into the video outputs
  always_comb begin
    de_s          = 1'b0;
    pixel_x_s     = CNT_ZERO;
    pixel_y_s     = CNT_ZERO;
    line_start_s  = 1'b0;
    frame_start_s = 1'b0;
    hsync_s       = ~cr_live_s[CR_HPOL_BIT];
    vsync_s       = ~cr_live_s[CR_VPOL_BIT];
    if (!idle_s) begin
      de_s          = (h_state_s == AXIS_ACTIVE) && (v_state_s == AXIS_ACTIVE);
      pixel_x_s     = de_s ? h_count_s : CNT_ZERO;
      pixel_y_s     = (v_state_s == AXIS_ACTIVE) ? v_count_s : CNT_ZERO;
      line_start_s  = (h_state_s == AXIS_ACTIVE) && (h_count_s == CNT_ZERO);
      frame_start_s = line_start_s && (v_state_s == AXIS_ACTIVE) && (v_count_s == CNT_ZERO);
      hsync_s       = (h_state_s == AXIS_SYNC) ? cr_sh_s[CR_HPOL_BIT] : ~cr_sh_s[CR_HPOL_BIT];
      vsync_s       = (v_state_s == AXIS_SYNC) ? cr_sh_s[CR_VPOL_BIT] : ~cr_sh_s[CR_VPOL_BIT];
    end else begin
      de_s          = 1'b0;
      line_start_s  = 1'b0;
      frame_start_s = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      de_r          <= 1'b0;
      pixel_x_r     <= CNT_ZERO;
      pixel_y_r     <= CNT_ZERO;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      hsync_r       <= ~cr_live_s[CR_HPOL_BIT];
      vsync_r       <= ~cr_live_s[CR_VPOL_BIT];
    end else begin
      de_r          <= de_s;
      pixel_x_r     <= pixel_x_s;
      pixel_y_r     <= pixel_y_s;
      line_start_r  <= line_start_s;
      frame_start_r <= frame_start_s;
      hsync_r       <= hsync_s;
      vsync_r       <= vsync_s;
    end
  end

  assign de          = de_r;
  assign pixel_x     = pixel_x_r;
  assign pixel_y     = pixel_y_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;

`ifdef VGA_TIMING_VBLANK_IRQ_EN
  logic irq_set_s;
  logic vblank_irq_r;

  assign irq_set_s = ~idle_s & h_last_s & (v_state_s == AXIS_ACTIVE) &
                     (v_count_s == (v_active_s - CNT_ONE));

  // Sticky vblank interrupt; a new set outranks a simultaneous ack
  always_ff @(posedge clock) begin
    if (reset) begin
      vblank_irq_r <= 1'b0;
    end else if (irq_set_s) begin
      vblank_irq_r <= 1'b1;
    end else if (irq_ack) begin
      vblank_irq_r <= 1'b0;
    end else begin
      vblank_irq_r <= vblank_irq_r;
    end
  end

  assign vblank_irq = vblank_irq_r;
`endif

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
Consumes the packed control register bus (TIMR0-TIMR9, VGACR0) from the VGA MMIO register bank. Generates hsync, vsync, data-enable and active-pixel coordinates for the pixel pipeline.
Runs on the pixel clock. Register values are shadowed and applied only at frame boundaries, so CPU writes never tear a frame.

Parameters:
DATA_WIDTH, 8, width of each control register
NUM_VGA_CONT_REG, 11, number of registers on the packed bus
CNT_WIDTH, 12, width of the h/v counters and of pixel_x/pixel_y; upper bits of 16-bit active lengths are ignored

Ports:
clock  in  1  pixel clock, all logic on rising edge
reset  in  1  reset, synchronous, active-high
control_reg_in  in  NUM_VGA_CONT_REG*DATA_WIDTH  packed registers; register n occupies bits [8n+7:8n]
hsync  out  1  horizontal sync, polarity per VGACR0[1]
vsync  out  1  vertical sync, polarity per VGACR0[2]
de  out  1  high when both axes are in ACTIVE
pixel_x  out  CNT_WIDTH  column within active line; 0 when de low
pixel_y  out  CNT_WIDTH  row within active frame; 0 outside vertical ACTIVE
line_start  out  1  one-cycle pulse on the first cycle of every line
frame_start  out  1  one-cycle pulse on the first cycle of every frame

Behaviour:
- Register map:
  - TIMR0/1: h_active lo/hi
  - TIMR2: h_front; TIMR3: h_sync; TIMR4: h_back
  - TIMR5/6: v_active lo/hi
  - TIMR7: v_front; TIMR8: v_sync; TIMR9: v_back
  - VGACR0[0]: enable; [1]: hsync active-high; [2]: vsync active-high; [7:3]: ignored
- Shadow registers:
  - Reset clears all shadows; the block is then idle.
  - All shadows load from control_reg_in when idle, and on the last cycle of a frame.
  - Between those loads, control_reg_in is ignored.
- Idle condition: shadow enable=0, or shadow h_active=0, or shadow v_active=0.
  - Outputs while idle: de=0, pixel_x=pixel_y=0, no pulses.
  - hsync/vsync sit at their inactive level per the live VGACR0 polarity bits.
  - Counters are held at 0, state is ACTIVE/ACTIVE.
- Axis FSMs:
  - One per axis, states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - A segment of length N occupies exactly N cycles (h) or N lines (v).
  - The segment counter runs 0..N-1 and resets on each transition.
  - Zero-length FRONT/SYNC/BACK segments are skipped; transitions go straight to the next non-zero segment. A zero sync length means no sync pulse.
- Line end = last cycle of the last non-zero h segment. The v FSM/counter advances only on line end.
- Frame end = line end on the last line of the last non-zero v segment.
- Line period = h_active+h_front+h_sync+h_back. Frame = line period × (v_active+v_front+v_sync+v_back).
- Output timing:
  - All outputs are registered and consistent with the counters in the same cycle.
  - pixel_x = h counter during h ACTIVE; pixel_y = v counter during v ACTIVE.
- Pulses:
  - line_start: first cycle after reset-release/idle-exit and after every line end.
  - frame_start: coincides with line_start on line 0.
- Sync polarity: sync asserted = level equal to the shadow polarity bit, inactive = its complement.
- Leaving idle: first cycle is pixel (0,0) with frame_start=1, one cycle after the shadows load.
- Clearing enable mid-frame takes effect at frame end only; the current frame always completes.
- Reset mid-frame: immediate return to idle; no partial pulses.

Optional Feature:
VGA_TIMING_VBLANK_IRQ_EN
- Defined:
  - Adds input irq_ack (1) and output vblank_irq (1).
  - vblank_irq sets on the line end that exits v ACTIVE and stays set until irq_ack=1.
  - Set wins over simultaneous ack. Reset clears it.
- Undefined: neither port exists and no logic is generated.

Decomposition:
- Shared package vga_pkg:
  - axis state enum (ACTIVE, FRONT, SYNC, BACK)
  - register index constants TIMR0..TIMR9, VGACR0
  - VGACR0 bit positions
- Sub-module vga_axis_counter: instantiated twice (h, v).
  - Inputs: advance, four segment lengths.
  - Outputs: state, counter, last (end of final segment).
  - Contains the zero-length skip logic.

Test Plan:
- Regs h=4/1/2/1, v=3/1/1/1, enable=1, both polarities active-high:
  - line period 8 cycles, frame 48 cycles
  - de high 4 cycles per line on lines 0-2
  - hsync high in cycles 5-6 of each line
  - vsync high on line 4
  - frame_start every 48 cycles
- Same config with h_front=0 and v_sync=0: line 7 cycles; hsync in cycles 4-5; vsync never asserts; frame 35 cycles.
- Write h_active=6 mid-frame: the current frame keeps 8-cycle lines; the next frame after frame_start uses 10-cycle lines.
- enable=0 or v_active=0: de=0, no pulses, syncs at the inactive level. Setting enable=1 gives frame_start with pixel (0,0) two cycles later.
- Polarities 0: hsync/vsync idle high and pulse low at the same cycles as scenario 1.
- Reset asserted mid-line: next cycle de=0, counters 0; outputs idle until the shadows reload.
- With VGA_TIMING_VBLANK_IRQ_EN:
  - irq sets at the end of line 2 and holds until irq_ack.
  - Ack coinciding with the next set leaves the irq set.
